// File: rtl/program_loader.sv
// Receives a program byte-stream from a UART receiver, assembles big-endian
// instruction words and writes them sequentially into instruction memory.
module program_loader #(
  parameter int                 NB_DATA      = 32,
  parameter int                 NB_BYTE      = 8,
  parameter int                 NB_ADDR      = 32,
  parameter int                 MEMORY_DEPTH = 64,
  parameter logic [NB_DATA-1:0] HALT_INSTR   = 32'hFFFFFFFF
) (
  input  logic               i_clock,
  input  logic               i_reset,
  input  logic               i_start,
  input  logic [NB_BYTE-1:0] i_rx_data,
  input  logic               i_rx_done,
  output logic               o_write_enable,
  output logic [NB_ADDR-1:0] o_write_addr,
  output logic [NB_DATA-1:0] o_write_data,
  output logic               o_busy,
  output logic               o_done,
  output logic               o_overflow,
  output logic [NB_ADDR-1:0] o_word_count
);

  localparam int BYTES_PER_WORD = NB_DATA / NB_BYTE;
  localparam int CNT_W          = (BYTES_PER_WORD > 1) ? $clog2(BYTES_PER_WORD) : 1;
  localparam int ASM_W          = NB_DATA - NB_BYTE;
  localparam logic [CNT_W-1:0]   LAST_BYTE = CNT_W'(BYTES_PER_WORD - 1);
  localparam logic [NB_ADDR-1:0] LAST_ADDR = NB_ADDR'(MEMORY_DEPTH - 1);

  typedef enum logic [2:0] {
    IDLE,
    RECEIVE,
    WRITE,
    DONE,
    ERROR
  } state_t;

  state_t             state;
  state_t             state_next;
  logic [CNT_W-1:0]   byte_cnt;
  logic [NB_ADDR-1:0] word_idx;
  // Only the leading bytes are stored; the final byte is taken straight from
  // i_rx_data when the completed word is latched into o_write_data.
  logic [ASM_W-1:0]   asm_reg;
  logic               last_byte;
  logic               start_session;

  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next    = state;
    last_byte     = (byte_cnt == LAST_BYTE);
    start_session = 1'b0;
    case (state)
      IDLE: begin
        if (i_start) begin
          state_next    = RECEIVE;
          start_session = 1'b1;
        end
      end
      RECEIVE: begin
        if (i_rx_done && last_byte) begin
          state_next = WRITE;
        end
      end
      WRITE: begin
        if (o_write_data == HALT_INSTR) begin
          state_next = DONE;
        end else if (word_idx == LAST_ADDR) begin
          state_next = ERROR;
        end else begin
          state_next = RECEIVE;
        end
      end
      DONE, ERROR: begin
        if (i_start) begin
          state_next    = RECEIVE;
          start_session = 1'b1;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Status flags are registered from the next state so they line up with it.
  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      byte_cnt       <= '0;
      word_idx       <= '0;
      asm_reg        <= '0;
      o_write_enable <= 1'b0;
      o_write_addr   <= '0;
      o_write_data   <= '0;
      o_busy         <= 1'b0;
      o_done         <= 1'b0;
      o_overflow     <= 1'b0;
      o_word_count   <= '0;
    end else begin
      o_write_enable <= (state_next == WRITE);
      o_busy         <= (state_next == RECEIVE) || (state_next == WRITE);
      o_done         <= (state_next == DONE);
      o_overflow     <= (state_next == ERROR);

      if (start_session) begin
        byte_cnt     <= '0;
        word_idx     <= '0;
        asm_reg      <= '0;
        o_word_count <= '0;
      end

      if (state == RECEIVE && i_rx_done) begin
        if (last_byte) begin
          byte_cnt     <= '0;
          o_write_addr <= word_idx;
          o_write_data <= {asm_reg, i_rx_data};
        end else begin
          byte_cnt <= byte_cnt + 1'b1;
        end
        if (ASM_W > NB_BYTE) begin
          asm_reg <= ASM_W'({asm_reg, i_rx_data});
        end else begin
          asm_reg <= ASM_W'(i_rx_data);
        end
      end

      if (state == WRITE) begin
        o_word_count <= o_word_count + 1'b1;
        if (state_next == RECEIVE) begin
          word_idx <= word_idx + 1'b1;
        end
      end
    end
  end

endmodule

// File: doc/program_loader.md
PROGRAM_LOADER -- requirements
Module: program_loader

Interface
REQ-001 SHALL have parameter NB_DATA, default 32, instruction word width.
REQ-002 SHALL have parameter NB_BYTE, default 8, received byte width.
REQ-003 SHALL have parameter NB_ADDR, default 32, instruction memory address width.
REQ-004 SHALL have parameter MEMORY_DEPTH, default 64, number of instruction memory words.
REQ-005 SHALL have parameter HALT_INSTR, default 32'hFFFFFFFF, end-of-program word.
REQ-006 SHALL have port i_clock  input  1  sole clock, rising edge.
REQ-007 SHALL have port i_reset  input  1  reset; one clock, reset synchronous and active-high.
REQ-008 SHALL have port i_start  input  1  begin a load session (level sampled each cycle).
REQ-009 SHALL have port i_rx_data  input  NB_BYTE  received byte from UART receiver.
REQ-010 SHALL have port i_rx_done  input  1  one-cycle strobe, i_rx_data valid.
REQ-011 SHALL have port o_write_enable  output  1  instruction memory write strobe.
REQ-012 SHALL have port o_write_addr  output  NB_ADDR  instruction memory word address.
REQ-013 SHALL have port o_write_data  output  NB_DATA  instruction memory write data.
REQ-014 SHALL have port o_busy  output  1  high in RECEIVE and WRITE.
REQ-015 SHALL have port o_done  output  1  high in DONE.
REQ-016 SHALL have port o_overflow  output  1  high in ERROR.
REQ-017 SHALL have port o_word_count  output  NB_ADDR  words written this session, HALT included.

Function
REQ-018 SHALL implement FSM states IDLE, RECEIVE, WRITE, DONE, ERROR.
REQ-019 IDLE: i_start=1 -> RECEIVE, clearing byte counter, word index, o_word_count; i_rx_done ignored.
REQ-020 RECEIVE: each i_rx_done shifts i_rx_data into assembly register; first byte of word = bits [31:24] (big-endian).
REQ-021 RECEIVE: byte counter counts 0..3; on 4th i_rx_done -> WRITE next cycle, counter wraps to 0.
REQ-022 WRITE SHALL last exactly one cycle: o_write_enable=1, o_write_addr=word index, o_write_data=assembled word.
REQ-023 Latency SHALL be 1 cycle: o_write_enable high in cycle after edge sampling the 4th i_rx_done.
REQ-024 o_word_count SHALL increment by 1 on leaving WRITE.
REQ-025 WRITE exit: word==HALT_INSTR -> DONE; else word index==MEMORY_DEPTH-1 -> ERROR; else index+1, -> RECEIVE.
REQ-026 i_rx_done during WRITE, DONE, ERROR SHALL be dropped; byte counter unchanged.
REQ-027 i_start in RECEIVE or WRITE SHALL be ignored.
REQ-028 DONE/ERROR: i_start=1 -> RECEIVE with counters cleared (new session, address restarts at 0).
REQ-029 o_write_enable SHALL be 0 in every state except WRITE; o_write_addr/o_write_data hold last values otherwise.
REQ-030 Outputs SHALL be registered; no combinational path from inputs to outputs.

Reset
REQ-031 i_reset=1 at rising edge SHALL force IDLE, byte counter 0, word index 0, assembly register 0.
REQ-032 Reset values: o_write_enable 0, o_write_addr 0, o_write_data 0, o_busy 0, o_done 0, o_overflow 0, o_word_count 0.
REQ-033 Reset SHALL take priority over i_start and i_rx_done in same cycle; reset mid-word discards partial bytes.

Verification
REQ-034 Reset, i_start, bytes 00 00 00 0A, 00 00 00 14, FF FF FF FF -> writes (0,0x0000000A),(1,0x00000014),(2,0xFFFFFFFF), o_done=1, o_word_count=3.
REQ-035 Bytes 12 34 56 78 -> one-cycle o_write_enable, addr 0, data 0x12345678, cycle after 4th strobe; o_busy=1 throughout.
REQ-036 64 non-HALT words -> addresses 0..63 written, o_overflow=1, o_word_count=64, further bytes produce no write.
REQ-037 i_reset after 2 bytes, then i_start and 4 bytes AA BB CC DD -> write addr 0, data 0xAABBCCDD.
REQ-038 i_rx_done with i_start=0 in IDLE -> no write; after DONE, i_start then HALT word -> write addr 0, o_done=1, o_word_count=1.
REQ-039 Bench SHALL check o_write_enable never high for more than one consecutive cycle.
